// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage.
package pipe_pkg;

  // Default payload: one RV32I word.
  typedef logic [31:0] word_t;

  // Width of an occupancy counter that must hold every value 0..depth.
  function automatic int pipe_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer that indexes depth entries (at least one bit).
  function automatic int pipe_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_elastic_ptr.sv
// Modulo-DEPTH wrap counter used as the read or write pointer of pipe_elastic.
// Wraps DEPTH-1 -> 0 explicitly, so DEPTH need not be a power of two.
module pipe_elastic_ptr #(
  parameter int DEPTH = 2,
  parameter int PW    = 1
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  // Next pointer: clear wins over increment; explicit wrap at the last entry.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      if (ptr_q == PW'(DEPTH - 1)) ptr_d = '0;
      else                         ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) ptr_q <= '0;
    else              ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/pipe_elastic.sv
// DEPTH-entry elastic valid/ready buffer between pipeline stages.
// ready_out is derived from registered occupancy only, so back-pressure never
// forms a combinational path from ready_in. No fall-through: a word accepted
// at one edge is visible on q after that edge.
// Optional feature: define PIPE_ELASTIC_STATS_EN to add the saturating
// stall_cycles counter (cycles with valid_out && !ready_in).
module pipe_elastic
  import pipe_pkg::*;
#(
  parameter type T            = word_t,
  parameter int  DEPTH        = 2,
  parameter int  AFULL_THRESH = DEPTH - 1,
`ifdef PIPE_ELASTIC_STATS_EN
  parameter int  CNT_W        = 16,
`endif
  localparam int CW           = pipe_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          sync_rst_n,
  input  logic          flush,
  input  T              d,
  input  logic          valid_in,
  output logic          ready_out,
  output T              q,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [CW-1:0] count,
  output logic          almost_full
`ifdef PIPE_ELASTIC_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam int PW = pipe_ptr_w(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, wr_en, clr;
  T              mem_q [DEPTH];

  assign push  = valid_in && ready_out;
  assign pop   = valid_out && ready_in;
  // Sync reset and flush both discard contents; a push in that cycle is dropped.
  assign clr   = !sync_rst_n || flush;
  assign wr_en = push && !clr;

  pipe_elastic_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clr_i       (clr),
    .inc_i       (wr_en),
    .ptr_o       (wr_ptr)
  );

  pipe_elastic_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clr_i       (clr),
    .inc_i       (pop),
    .ptr_o       (rd_ptr)
  );

  // Occupancy next state: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) count_q <= '0;
    else              count_q <= count_d;
  end

  // Payload storage: written only on an accepted push, never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= d;
  end

  assign count       = count_q;
  assign valid_out   = (count_q != '0);
  assign ready_out   = (count_q != CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AFULL_THRESH));
  assign q           = valid_out ? mem_q[rd_ptr] : '0;

`ifdef PIPE_ELASTIC_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stall counter next state: cleared by sync reset only, flush leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (!sync_rst_n)                   stall_d = '0;
    else if (valid_out && !ready_in)   stall_d = sat_inc(stall_q);
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) stall_q <= '0;
    else              stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
